// File: rtl/sha256_pkg.sv
// Shared constants, state encoding and block-count helper for the SHA-256 message padder.
package sha256_pkg;

   localparam int unsigned WORD_W      = 32;
   localparam int unsigned SIZE_W      = 12;
   localparam int unsigned BLOCK_WORDS = 16;
   localparam int unsigned IDX_W       = 4;
   localparam int unsigned NBLK_W      = 9;
   localparam int unsigned POS_W       = 13;

   localparam logic [WORD_W-1:0] PAD_WORD = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MSG  = 2'd1,
      PAD  = 2'd2,
      DONE = 2'd3
   } padder_state_t;

   // Blocks needed for size words plus the pad word and the two length words.
   function automatic logic [NBLK_W-1:0] calc_num_blocks(input logic [SIZE_W-1:0] size);
      logic [POS_W-1:0] s2;
      s2 = POS_W'(size) + POS_W'(2);
      return NBLK_W'(s2 >> 4) + NBLK_W'(1);
   endfunction

endpackage

// File: rtl/sha256_msg_padder.sv
// Streaming SHA-256 padder: forwards message words, then appends the pad word,
// zero fill and 64-bit bit-length as whole 16-word blocks.
module sha256_msg_padder #(
   parameter int unsigned WORD_W = 32,
   parameter int unsigned SIZE_W = 12
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [SIZE_W-1:0] size,
   output logic              busy,
   output logic [8:0]        num_blocks,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_data,
   output logic [3:0]        out_word_idx,
   output logic              out_block_last,
   output logic              out_msg_last,
   output logic              done
);
   import sha256_pkg::*;

   padder_state_t     state_q, state_d;
   logic [SIZE_W-1:0] size_q, size_d;
   logic [NBLK_W-1:0] nblk_q, nblk_d;
   logic [POS_W-1:0]  pos_q, pos_d;
   logic [POS_W-1:0]  msg_cnt_q, msg_cnt_d;
   logic              busy_q, busy_d;
   logic              out_valid_q, out_valid_d;
   logic [WORD_W-1:0] out_data_q, out_data_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              blast_q, blast_d;
   logic              mlast_q, mlast_d;
   logic              done_q, done_d;

   logic [POS_W-1:0]  total_c;
   logic              load_ok_c;
   logic              in_ready_c;
   logic              load_c;
   logic [WORD_W-1:0] load_word_c;
   logic [WORD_W-1:0] pad_word_c;

   assign total_c    = {nblk_q, 4'b0000};
   assign load_ok_c  = !out_valid_q || out_ready;
   assign in_ready_c = (state_q == MSG) && load_ok_c && (msg_cnt_q < POS_W'(size_q));

   // Padding content for a position at or beyond the end of the message.
   always_comb begin
      pad_word_c = '0;
      if (pos_q == POS_W'(size_q)) begin
         pad_word_c = WORD_W'(PAD_WORD);
      end else if (pos_q == total_c - POS_W'(1)) begin
         pad_word_c = WORD_W'({size_q, 5'b00000});
      end
   end

   always_comb begin
      state_d     = state_q;
      size_d      = size_q;
      nblk_d      = nblk_q;
      pos_d       = pos_q;
      msg_cnt_d   = msg_cnt_q;
      busy_d      = busy_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      idx_d       = idx_q;
      blast_d     = blast_q;
      mlast_d     = mlast_q;
      done_d      = 1'b0;
      load_c      = 1'b0;
      load_word_c = '0;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               size_d    = size;
               nblk_d    = calc_num_blocks(size);
               pos_d     = '0;
               msg_cnt_d = '0;
               busy_d    = 1'b1;
               state_d   = (size != '0) ? MSG : PAD;
            end
         end
         MSG: begin
            if (in_valid && in_ready_c) begin
               load_c      = 1'b1;
               load_word_c = in_data;
               msg_cnt_d   = msg_cnt_q + POS_W'(1);
               if (msg_cnt_d == POS_W'(size_q)) begin
                  state_d = PAD;
               end
            end
         end
         PAD: begin
            if (pos_q < total_c) begin
               if (load_ok_c) begin
                  load_c      = 1'b1;
                  load_word_c = pad_word_c;
               end
            end else if (out_valid_q && out_ready) begin
               // Final word accepted: stream is complete.
               state_d = DONE;
               done_d  = 1'b1;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (load_c) begin
         out_valid_d = 1'b1;
         out_data_d  = load_word_c;
         idx_d       = pos_q[IDX_W-1:0];
         blast_d     = (pos_q[IDX_W-1:0] == 4'hF);
         mlast_d     = (pos_q == total_c - POS_W'(1));
         pos_d       = pos_q + POS_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         size_q      <= '0;
         nblk_q      <= '0;
         pos_q       <= '0;
         msg_cnt_q   <= '0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         idx_q       <= '0;
         blast_q     <= 1'b0;
         mlast_q     <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         size_q      <= size_d;
         nblk_q      <= nblk_d;
         pos_q       <= pos_d;
         msg_cnt_q   <= msg_cnt_d;
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         idx_q       <= idx_d;
         blast_q     <= blast_d;
         mlast_q     <= mlast_d;
         done_q      <= done_d;
      end
   end

   assign busy           = busy_q;
   assign num_blocks     = nblk_q;
   assign in_ready       = in_ready_c;
   assign out_valid      = out_valid_q;
   assign out_data       = out_data_q;
   assign out_word_idx   = idx_q;
   assign out_block_last = blast_q;
   assign out_msg_last   = mlast_q;
   assign done           = done_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Scoreboard bench for sha256_msg_padder: a reference model of SHA-256 padding
// fills an expected-word queue that a negedge monitor drains against the DUT.
module tb_sha256_msg_padder;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        start = 1'b0;
   logic [11:0] size = '0;
   logic        busy;
   logic [8:0]  num_blocks;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [3:0]  out_word_idx;
   logic        out_block_last;
   logic        out_msg_last;
   logic        done;

   sha256_msg_padder dut (
      .clk(clk), .reset_n(reset_n), .start(start), .size(size),
      .busy(busy), .num_blocks(num_blocks),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_word_idx(out_word_idx), .out_block_last(out_block_last),
      .out_msg_last(out_msg_last), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  idx;
      logic        blast;
      logic        mlast;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] msg[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          accepted = 0;
   int          busy_cycles = 0;
   int          rdy_pct = 100;
   bit          expect_done = 1'b0;
   bit          hold_vld = 1'b0;
   logic [31:0] hold_data = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference padding: message, 0x80000000, zeros, 64-bit bit length, rounded to 16 words.
   function automatic int build_expected(input int sz);
      int total;
      exp_t e;
      total = ((sz + 3 + 15) / 16) * 16;
      for (int j = 0; j < total; j++) begin
         if (j < sz)             e.data = msg[j];
         else if (j == sz)       e.data = 32'h8000_0000;
         else if (j == total-1)  e.data = 32'(sz * 32);
         else                    e.data = 32'h0;
         e.idx   = 4'(j % 16);
         e.blast = (j % 16) == 15;
         e.mlast = (j == total - 1);
         exp_q.push_back(e);
      end
      return total;
   endfunction

   always @(posedge clk) begin
      #1;
      out_ready = ($urandom_range(99) < 32'(rdy_pct));
   end

   // Monitor: a word is consumed at the next rising edge when valid && ready at the falling edge.
   always @(negedge clk) begin
      if (!reset_n) begin
         hold_vld = 1'b0;
      end else begin
         if (busy) busy_cycles++;
         if (expect_done) begin
            check("done_pulse", 64'(done), 64'(1));
            check("busy_in_done", 64'(busy), 64'(1));
            expect_done = 1'b0;
         end else if (done) begin
            check("spurious_done", 64'(done), 64'(0));
         end
         if (hold_vld && out_valid) check("stall_stable", 64'(out_data), 64'(hold_data));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_word", 64'(out_data), 64'hDEAD_0000_0000_0000);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("out_data", 64'(out_data), 64'(e.data));
               check("out_word_idx", 64'(out_word_idx), 64'(e.idx));
               check("out_block_last", 64'(out_block_last), 64'(e.blast));
               check("out_msg_last", 64'(out_msg_last), 64'(e.mlast));
               if (e.mlast) expect_done = 1'b1;
            end
            accepted++;
            hold_vld = 1'b0;
         end else if (out_valid) begin
            hold_vld  = 1'b1;
            hold_data = out_data;
         end else begin
            hold_vld = 1'b0;
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, 64'(busy), 64'(0));
      check({tag, "_in_ready"}, 64'(in_ready), 64'(0));
      check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
      check({tag, "_out_data"}, 64'(out_data), 64'(0));
      check({tag, "_out_word_idx"}, 64'(out_word_idx), 64'(0));
      check({tag, "_out_block_last"}, 64'(out_block_last), 64'(0));
      check({tag, "_out_msg_last"}, 64'(out_msg_last), 64'(0));
      check({tag, "_done"}, 64'(done), 64'(0));
      check({tag, "_num_blocks"}, 64'(num_blocks), 64'(0));
   endtask

   task automatic run_msg(input int sz, input int vpct, input int rpct,
                          input bit midstart, input int abort_after);
      int total;
      int idx;
      int cycles;
      bit mid_done;
      rdy_pct = rpct;
      msg.delete();
      for (int j = 0; j < sz; j++) msg.push_back($urandom);
      total = build_expected(sz);
      @(posedge clk); #1;
      @(posedge clk); #1;
      accepted    = 0;
      busy_cycles = 0;
      size  = 12'(sz);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      size  = 12'($urandom);
      check("num_blocks", 64'(num_blocks), 64'(total / 16));
      check("busy_after_start", 64'(busy), 64'(1));
      idx = 0;
      cycles = 0;
      mid_done = 1'b0;
      while (cycles < 20000 && !(idx == sz && exp_q.size() == 0 && !busy)) begin
         if (abort_after > 0 && accepted >= abort_after) begin
            reset_n = 1'b0;
            #1;
            check_all_zero("async_reset");
            exp_q.delete();
            expect_done = 1'b0;
            in_valid = 1'b0;
            start = 1'b0;
            @(negedge clk);
            @(negedge clk);
            reset_n = 1'b1;
            return;
         end
         in_valid = (idx < sz) && ($urandom_range(99) < 32'(vpct));
         in_data  = (idx < sz) ? msg[idx] : 32'($urandom);
         if (midstart && !mid_done && idx == sz / 2) begin
            start = 1'b1;
            size  = 12'd1;
            mid_done = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         if (in_valid && in_ready) idx++;
         @(posedge clk); #1;
         cycles++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      check("drain_left", 64'(exp_q.size()), 64'(0));
      check("busy_end", 64'(busy), 64'(0));
      check("num_blocks_held", 64'(num_blocks), 64'(total / 16));
      if (vpct == 100 && rpct == 100) check("busy_cycles", 64'(busy_cycles), 64'(total + 2));
   endtask

   initial begin
      #1 reset_n = 1'b0;
      #1 check_all_zero("reset");
      repeat (3) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      #1 check_all_zero("post_reset");

      run_msg(0, 100, 100, 1'b0, 0);
      run_msg(13, 100, 100, 1'b0, 0);
      run_msg(14, 100, 100, 1'b0, 0);
      run_msg(15, 100, 100, 1'b0, 0);
      run_msg(16, 100, 100, 1'b0, 0);
      run_msg(20, 100, 100, 1'b0, 0);
      run_msg(20, 50, 50, 1'b1, 0);
      run_msg(40, 100, 100, 1'b0, 20);
      run_msg(1, 100, 100, 1'b0, 0);
      for (int r = 0; r < 8; r++) begin
         run_msg(int'($urandom_range(0, 70)), int'($urandom_range(30, 100)),
                 int'($urandom_range(30, 100)), 1'($urandom_range(0, 1)), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
